// File: rtl/md_sched.sv
// Multiply/divide sequencer with HI/LO ownership for the E stage.
// Latency: fixed MULT_CYCLES or DIV_CYCLES busy cycles after issue; mthi/mtlo take one edge.
// Backpressure: stall = d_md & (start | busy) holds MD-class ops in D until the unit is free.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_md,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // The counter is loaded with latency-1 so the write lands on the N-th busy edge.
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Operation kind latched at issue: 0 mult, 1 multu, 2 div, 3 divu.
    localparam logic [1:0] K_MULT  = 2'd0;
    localparam logic [1:0] K_MULTU = 2'd1;
    localparam logic [1:0] K_DIV   = 2'd2;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [1:0]        r_kind;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;

    logic              w_is_issue;
    logic              w_start;
    logic              w_done;
    logic              w_div0;
    logic signed [63:0] w_prod_s;
    logic [63:0]       w_prod_u;
    logic [31:0]       w_quo_s;
    logic [31:0]       w_rem_s;
    logic [31:0]       w_quo_u;
    logic [31:0]       w_rem_u;

    // Issue decode; start is forced low while reset is held so the stall path stays quiet.
    assign w_is_issue = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
    assign w_start    = reset && (r_state == S_IDLE) && w_is_issue;
    assign w_done     = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_div0     = (r_b == 32'd0);

    // Arithmetic works only from the latched operands, never from the live E-stage values.
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_quo_s  = $signed(r_a) / $signed(r_b);
    assign w_rem_s  = $signed(r_a) % $signed(r_b);
    assign w_quo_u  = r_a / r_b;
    assign w_rem_u  = r_a % r_b;

    // Next-state and counter: load on issue, count down while busy, return to idle at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = (e_op <= OP_MULTU) ? MULT_LAT : DIV_LAT;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operand and kind capture at the issue edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind <= 2'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
        end else if (w_start) begin
            r_kind <= 2'(e_op - OP_MULT);
            r_a    <= e_rs;
            r_b    <= e_rt;
        end
    end

    // HI/LO: result write on the final busy edge (skipped for divide by zero), else mthi/mtlo when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            case (r_kind)
                K_MULT: begin
                    r_hi <= w_prod_s[63:32];
                    r_lo <= w_prod_s[31:0];
                end
                K_MULTU: begin
                    r_hi <= w_prod_u[63:32];
                    r_lo <= w_prod_u[31:0];
                end
                K_DIV: begin
                    if (!w_div0) begin
                        r_hi <= w_rem_s;
                        r_lo <= w_quo_s;
                    end
                end
                default: begin
                    if (!w_div0) begin
                        r_hi <= w_rem_u;
                        r_lo <= w_quo_u;
                    end
                end
            endcase
        end else if ((r_state == S_IDLE) && !w_start) begin
            if (e_op == OP_MTHI) begin
                r_hi <= e_rs;
            end
            if (e_op == OP_MTLO) begin
                r_lo <= e_rs;
            end
        end
    end

    // Read mux for mfhi/mflo; HI/LO are zero under reset so this reads zero then too.
    always_comb begin
        md_rdata = 32'd0;
        if (e_op == OP_MFHI) begin
            md_rdata = r_hi;
        end else if (e_op == OP_MFLO) begin
            md_rdata = r_lo;
        end
    end

    assign start = w_start;
    assign busy  = (r_state == S_BUSY);
    assign stall = d_md && (w_start || busy);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus randomized ops against a HI/LO model.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
// The model keeps HI/LO as plain integers and derives results with native 64-bit arithmetic.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int ntot  = 0;
    int npass = 0;
    int nfail = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .e_op     (e_op),
        .e_rs     (e_rs),
        .e_rt     (e_rt),
        .d_md     (d_md),
        .start    (start),
        .busy     (busy),
        .stall    (stall),
        .md_rdata (md_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {HI,LO} after an op, from the architectural definition of each instruction.
    function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        longint          p;
        longint unsigned up;
        int              q;
        int              r;
        case (op)
            1: begin
                p = longint'(int'(a)) * longint'(int'(b));
                return p;
            end
            2: begin
                up = longint'(a) * longint'(b);
                return up;
            end
            3: begin
                if (b == 32'd0) return {h, l};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {h, l};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one mult/div, follow its busy window, then check HI/LO in the first free cycle.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic dmd);
        logic [63:0] res;
        int          n;
        res = model(op, a, b, m_hi, m_lo);
        n   = (op <= 2) ? 5 : 10;
        @(negedge clk);
        e_op = 4'(op); e_rs = a; e_rt = b; d_md = dmd;
        #1;
        chk("start_at_issue", 32'(start), 32'd1);
        chk("stall_at_issue", 32'(stall), 32'(dmd));
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e_op = 4'd0;
            #1;
            chk("busy_window", 32'(busy), 32'd1);
            chk("stall_window", 32'(stall), 32'(dmd));
            chk("hi_held_busy", hi, m_hi);
        end
        m_hi = res[63:32];
        m_lo = res[31:0];
        @(negedge clk);
        #1;
        chk("busy_done", 32'(busy), 32'd0);
        chk("stall_done", 32'(stall), 32'd0);
        chk("hi_result", hi, m_hi);
        chk("lo_result", lo, m_lo);
    endtask

    // mthi/mtlo followed by an mfhi/mflo read in the next cycle.
    task automatic move_to(input logic to_hi, input logic [31:0] v);
        @(negedge clk);
        e_op = to_hi ? 4'd7 : 4'd8; e_rs = v;
        if (to_hi) m_hi = v; else m_lo = v;
        @(negedge clk);
        e_op = to_hi ? 4'd5 : 4'd6;
        #1;
        chk(to_hi ? "mfhi_after_mthi" : "mflo_after_mtlo", md_rdata, v);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          rop;

        // Reset state: everything low even with an issuing op and an MD op in D.
        reset = 1'b0; e_op = 4'd1; e_rs = 32'd5; e_rt = 32'd6; d_md = 1'b1;
        #12;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        e_op = 4'd5;
        #1;
        chk("rst_rdata", md_rdata, 32'd0);

        // Idle with no op for 20 cycles.
        @(negedge clk);
        reset = 1'b1; e_op = 4'd0; d_md = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Signed mult -2 * 3.
        run_op(1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFFA);

        // Signed div -7 / 2.
        run_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_hi_const", hi, 32'hFFFF_FFFF);

        // divu by zero leaves preloaded HI/LO alone.
        move_to(1'b1, 32'h11);
        move_to(1'b0, 32'h22);
        run_op(4, 32'd1234, 32'd0, 1'b0);
        chk("div0_hi_const", hi, 32'h11);
        chk("div0_lo_const", lo, 32'h22);

        // Structural stall with multu, then mflo in the first free cycle.
        run_op(2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        e_op = 4'd6; d_md = 1'b0;
        #1;
        chk("mflo_after_stall", md_rdata, 32'hFFFF_FFFE);
        chk("hi_after_multu", hi, 32'h1);

        // Ops presented while busy must be ignored (no mthi write, no re-issue).
        @(negedge clk);
        e_op = 4'd1; e_rs = 32'd7; e_rt = 32'd7;
        @(negedge clk);
        e_op = 4'd7; e_rs = 32'hDEAD_BEEF;
        #1;
        chk("busy_after_issue", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) @(negedge clk);
        e_op = 4'd0;
        m_hi = 32'd0; m_lo = 32'd49;
        @(negedge clk);
        #1;
        chk("ignored_op_busy", 32'(busy), 32'd0);
        chk("ignored_op_hi", hi, m_hi);
        chk("ignored_op_lo", lo, m_lo);

        // Randomized ops, back-to-back, against the model.
        for (int k = 0; k < 12; k++) begin
            rop = $urandom_range(1, 4);
            ra  = $urandom;
            rb  = $urandom;
            if (k % 3 == 0) rb = $urandom_range(0, 9);
            if (rop == 3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            if (k % 4 == 1) move_to(1'b1, $urandom);
            run_op(rop, ra, rb, 1'(k % 2));
        end

        // Reset mid-divide aborts at once and clears HI/LO.
        @(negedge clk);
        e_op = 4'd3; e_rs = 32'd100; e_rt = 32'd7; d_md = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e_op = 4'd0;
        end
        @(negedge clk);
        reset = 1'b0; d_md = 1'b1; e_op = 4'd1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_start", 32'(start), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1; e_op = 4'd0; d_md = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op(1, 32'd3, 32'd4, 1'b0);
        chk("post_rst_lo", lo, 32'd12);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
